memory_copier: RTL
==================

Name: memory_copier

Overview:
- Command-driven initiator for the 8-bit register-file memory: drives its read port, write port and write strobe to copy a block of cells from a source range to a destination range, one cell per clock.
- Sits beside the CPU datapath as a small DMA engine sharing the memory port, which is muxed upstream.
- Handles overlapping ranges with memmove semantics and wraps addresses modulo 2^ADDRESS_WIDTH.

Parameters:
- ADDRESS_WIDTH, 8, memory address width; the cell count is 2^ADDRESS_WIDTH.
- DATA_WIDTH, 8, memory cell width.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  copier able to accept a command
- cmd_source  input  ADDRESS_WIDTH  first source address
- cmd_destination  input  ADDRESS_WIDTH  first destination address
- cmd_length  input  ADDRESS_WIDTH+1  cell count, 0..2^ADDRESS_WIDTH
- busy  output  1  copy in progress
- done  output  1  one-cycle pulse at the end of each command
- mem_read_address  output  ADDRESS_WIDTH  to memory read_address
- mem_read_data  input  DATA_WIDTH  from memory read_data; combinational, same cycle
- mem_write_address  output  ADDRESS_WIDTH  to memory write_address
- mem_write_data  output  DATA_WIDTH  to memory write_data
- mem_write_enable  output  1  to memory write_enable

Behaviour:
- Reset:
  - State IDLE; cmd_ready=1; busy=0; done=0.
  - mem_write_enable=0; all address registers 0.
  - Asserting reset mid-copy drops mem_write_enable immediately and abandons the copy. Cells already written stay written; no done is issued.
- State machine:
  - IDLE, COPY, DONE.
  - cmd_ready=1 only in IDLE.
  - busy=1 in COPY.
  - done=1 only in DONE.
- Accept: cmd_valid && cmd_ready at a rising edge.
  - Length values above 2^ADDRESS_WIDTH saturate to 2^ADDRESS_WIDTH.
  - Length 0 goes IDLE->DONE with no write.
  - Otherwise IDLE->COPY.
- Direction is fixed at accept. Let delta = (destination - source) mod 2^ADDRESS_WIDTH.
  - Descending when 1 <= delta < length.
  - Ascending otherwise, including delta=0.
  - Ascending start: src=source, dst=destination.
  - Descending start: src=source+length-1, dst=destination+length-1, both modulo 2^ADDRESS_WIDTH.
- COPY, each cycle:
  - mem_read_address=src; mem_write_address=dst.
  - mem_write_data=mem_read_data, combinational pass-through; mem_write_enable=1.
  - At the edge, src and dst step +1 (ascending) or -1 (descending), wrapping modulo 2^ADDRESS_WIDTH, and the remaining count decrements.
  - When the count reaches 0: COPY->DONE.
  - Exactly `length` writes, one per cycle, no gaps.
- Latency: accept edge to first write is 1 cycle. Accept to done is length+1 cycles (length 0: done 1 cycle after accept).
- DONE->IDLE after one cycle. A new command can be accepted the cycle after done.
- Outside COPY:
  - mem_write_enable=0.
  - Addresses hold their last values.
  - Command inputs are ignored unless cmd_ready=1.

Optional Feature:
- Macro: MEMORY_COPIER_FILL_EN.
- Defined:
  - Adds ports cmd_fill (input, 1) and cmd_fill_value (input, DATA_WIDTH), both sampled at accept.
  - When cmd_fill=1, COPY writes the latched fill value to `length` ascending destination cells; mem_read_data is ignored and mem_read_address holds.
  - Direction logic is bypassed in fill mode.
- Undefined: the ports are absent and every command is a copy.

Test Plan:
- Preload cells 0x10..0x13 = 0xA1..0xA4; command src=0x10, dst=0x40, len=4 -> writes to 0x40..0x43 in 4 consecutive cycles; done pulses 5 cycles after accept; cells 0x40..0x43 = 0xA1..0xA4.
- Overlap: cells 0x20..0x23 = 1,2,3,4; command src=0x20, dst=0x21, len=4 -> descending write order 0x24,0x23,0x22,0x21; final 0x20..0x24 = 1,1,2,3,4.
- Wrap: cells 0xFE,0xFF,0x00 = 7,8,9; command src=0xFE, dst=0x80, len=3 -> cells 0x80..0x82 = 7,8,9.
- Length 0 -> no write-enable cycle; done exactly 1 cycle after accept. Length 0x1FF -> exactly 256 writes.
- Assert reset after 2 of 8 writes -> write_enable drops at once; cmd_ready=1; no done; first 2 destination cells updated.
- With MEMORY_COPIER_FILL_EN: fill=1, value 0x5A, dst=0x30, len=3 -> cells 0x30..0x32 = 0x5A. Back-to-back commands are accepted the cycle after done.

Source files
------------

// File: rtl/memory_copier.sv
// memory_copier: command-driven block copier for the register-file memory.
// Copies cmd_length cells from cmd_source to cmd_destination, one cell per clock,
// with memmove semantics for overlapping ranges and addresses wrapping modulo
// 2^ADDRESS_WIDTH.
//
// Optional feature macro: MEMORY_COPIER_FILL_EN adds cmd_fill / cmd_fill_value,
// turning a command into an ascending fill of the destination range.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   cmd_valid / cmd_ready        command handshake (ready only when idle)
//   cmd_source, cmd_destination  first source / destination address
//   cmd_length                   cell count 0..2^ADDRESS_WIDTH (larger values saturate)
//   busy                         high while cells are being written
//   done                         one-cycle pulse at the end of each command
//   mem_read_address/_data       memory read port (read data is combinational)
//   mem_write_address/_data/_enable  memory write port
module memory_copier #(
   parameter int ADDRESS_WIDTH = 8,
   parameter int DATA_WIDTH    = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [ADDRESS_WIDTH-1:0] cmd_source,
   input  logic [ADDRESS_WIDTH-1:0] cmd_destination,
   input  logic [ADDRESS_WIDTH:0]   cmd_length,
`ifdef MEMORY_COPIER_FILL_EN
   input  logic                     cmd_fill,
   input  logic [DATA_WIDTH-1:0]    cmd_fill_value,
`endif
   output logic                     busy,
   output logic                     done,
   output logic [ADDRESS_WIDTH-1:0] mem_read_address,
   input  logic [DATA_WIDTH-1:0]    mem_read_data,
   output logic [ADDRESS_WIDTH-1:0] mem_write_address,
   output logic [DATA_WIDTH-1:0]    mem_write_data,
   output logic                     mem_write_enable
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_COPY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [ADDRESS_WIDTH:0] MAX_LENGTH = {1'b1, {ADDRESS_WIDTH{1'b0}}};
   localparam logic [ADDRESS_WIDTH:0] COUNT_ONE  = {{ADDRESS_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]               state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] src_q, src_d;
   logic [ADDRESS_WIDTH-1:0] dst_q, dst_d;
   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic                     descending_q, descending_d;

   // Decode of the offered command, only used at the accept edge.
   logic [ADDRESS_WIDTH:0]   length_sat;
   logic [ADDRESS_WIDTH-1:0] delta;
   logic [ADDRESS_WIDTH-1:0] length_minus_one;
   logic                     cmd_descending;
   logic                     accept;
   logic                     fill_cmd;
   logic                     fill_active;

`ifdef MEMORY_COPIER_FILL_EN
   logic                  fill_q, fill_d;
   logic [DATA_WIDTH-1:0] fill_value_q, fill_value_d;

   assign fill_cmd    = cmd_fill;
   assign fill_active = fill_q;

   always_comb begin
      fill_d       = fill_q;
      fill_value_d = fill_value_q;
      if (accept) begin
         fill_d       = cmd_fill;
         fill_value_d = cmd_fill_value;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fill_q       <= 1'b0;
         fill_value_q <= '0;
      end else begin
         fill_q       <= fill_d;
         fill_value_q <= fill_value_d;
      end
   end
`else
   assign fill_cmd    = 1'b0;
   assign fill_active = 1'b0;
`endif

   assign accept = cmd_valid && (state_q == ST_IDLE);

   always_comb begin
      length_sat       = (cmd_length > MAX_LENGTH) ? MAX_LENGTH : cmd_length;
      delta            = cmd_destination - cmd_source;
      // Low bits of a saturated full-range length are zero, so minus one wraps
      // to the last cell, which is exactly the offset wanted.
      length_minus_one = length_sat[ADDRESS_WIDTH-1:0] - ADDR_ONE;
      // Destination starts inside the source range: copy from the top down so
      // source cells are read before they are overwritten.
      cmd_descending   = (delta != '0) && ({1'b0, delta} < length_sat) && !fill_cmd;
   end

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      count_d      = count_q;
      descending_d = descending_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (length_sat == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d      = ST_COPY;
                  count_d      = length_sat;
                  descending_d = cmd_descending;
                  if (cmd_descending) begin
                     src_d = cmd_source + length_minus_one;
                     dst_d = cmd_destination + length_minus_one;
                  end else begin
                     dst_d = cmd_destination;
                     // A fill leaves the read address where it was.
                     if (!fill_cmd) begin
                        src_d = cmd_source;
                     end
                  end
               end
            end
         end
         ST_COPY: begin
            count_d = count_q - COUNT_ONE;
            if (descending_q) begin
               src_d = src_q - ADDR_ONE;
               dst_d = dst_q - ADDR_ONE;
            end else begin
               dst_d = dst_q + ADDR_ONE;
               if (!fill_active) begin
                  src_d = src_q + ADDR_ONE;
               end
            end
            if (count_q == COUNT_ONE) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         count_q      <= '0;
         descending_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         count_q      <= count_d;
         descending_q <= descending_d;
      end
   end

   // Write enable is decoded from state so an asynchronous reset drops it at once.
   always_comb begin
      cmd_ready         = (state_q == ST_IDLE);
      busy              = (state_q == ST_COPY);
      done              = (state_q == ST_DONE);
      mem_write_enable  = (state_q == ST_COPY);
      mem_read_address  = src_q;
      mem_write_address = dst_q;
      mem_write_data    = mem_read_data;
`ifdef MEMORY_COPIER_FILL_EN
      if (fill_q) begin
         mem_write_data = fill_value_q;
      end
`endif
   end

endmodule
